// File: rtl/radig_pkg.sv
// rtl/radig_pkg.sv - shared types and constants for the truth-table sweeper
package radig_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    // Golden table of F = (C&D | B)&A | B&~C, bit i = F at {A,B,C,D} = i
    localparam logic [15:0] TT_F32A = 16'hF830;

    localparam int IDX_W = 4;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// rtl/truth_table_sweeper_settle_timer.sv - per-index settle down-counter
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on entry to a new index, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Zero means this is the last settle cycle of the current index
    assign expire = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps {a,b,c,d} 0..15, captures f_in, compares to EXPECTED; SWEEP_FAIL_LOG_EN adds first-fail log
module truth_table_sweeper
    import radig_pkg::*;
#(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = TT_F32A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
`ifdef SWEEP_FAIL_LOG_EN
    output logic        fail_valid,
    output logic [3:0]  fail_idx,
`endif
    output logic        pass
);

    sweep_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      table_q, table_d;
    logic             pass_q, pass_d;
    logic             settle_load;
    logic             settle_expire;
`ifdef SWEEP_FAIL_LOG_EN
    logic             fail_valid_q, fail_valid_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
`endif

    // Timer restarts on every entry into DRIVE, i.e. once per index
    assign settle_load = (state_d == DRIVE) && (state_q != DRIVE);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (settle_load),
        .expire (settle_expire)
    );

    // Sweep sequencing, capture of f_in and the registered verdict
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        table_d = table_q;
        pass_d  = pass_q;
`ifdef SWEEP_FAIL_LOG_EN
        fail_valid_d = fail_valid_q;
        fail_idx_d   = fail_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    table_d = '0;
                    pass_d  = 1'b0;
`ifdef SWEEP_FAIL_LOG_EN
                    fail_valid_d = 1'b0;
                    fail_idx_d   = '0;
`endif
                end
            end
            DRIVE: begin
                if (settle_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                table_d[idx_q] = f_in;
`ifdef SWEEP_FAIL_LOG_EN
                if (!fail_valid_q && (f_in != EXPECTED[idx_q])) begin
                    fail_valid_d = 1'b1;
                    fail_idx_d   = idx_q;
                end
`endif
                if (idx_q == {IDX_W{1'b1}}) begin
                    // Compare the table including the bit captured this cycle,
                    // so pass is already valid while done is high
                    state_d = DONE;
                    pass_d  = (table_d == EXPECTED);
                end else begin
                    idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    state_d = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
`ifdef SWEEP_FAIL_LOG_EN
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            pass_q  <= pass_d;
`ifdef SWEEP_FAIL_LOG_EN
            fail_valid_q <= fail_valid_d;
            fail_idx_q   <= fail_idx_d;
`endif
        end
    end

    assign {a, b, c, d} = idx_q;
    assign busy         = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done         = (state_q == DONE);
    assign table_out    = table_q;
    assign pass         = pass_q;
`ifdef SWEEP_FAIL_LOG_EN
    assign fail_valid   = fail_valid_q;
    assign fail_idx     = fail_idx_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper (SETTLE=1 and SETTLE=3 instances)
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start3;
    logic        f1, f3;
    logic        a1, b1, c1, d1, busy1, done1, pass1;
    logic        a3, b3, c3, d3, busy3, done3, pass3;
    logic [15:0] tbl1, tbl3;
`ifdef SWEEP_FAIL_LOG_EN
    logic        fv1, fv3;
    logic [3:0]  fi1, fi3;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mode_v;
    logic [15:0] tt_v;

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .table_out(tbl1),
`ifdef SWEEP_FAIL_LOG_EN
        .fail_valid(fv1), .fail_idx(fi1),
`endif
        .pass(pass1)
    );

    truth_table_sweeper #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f3),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .table_out(tbl3),
`ifdef SWEEP_FAIL_LOG_EN
        .fail_valid(fv3), .fail_idx(fi3),
`endif
        .pass(pass3)
    );

    // Reference functions: 0 golden, 1 stuck-at-0, 2 golden flipped at index 11, 3 arbitrary table
    function automatic logic f_model(input int mode, input logic [15:0] tt, input logic [3:0] i);
        logic ga, gb, gc, gd, g;
        {ga, gb, gc, gd} = i;
        g = (((gc & gd) | gb) & ga) | (gb & ~gc);
        case (mode)
            0:       return g;
            1:       return 1'b0;
            2:       return g ^ (i == 4'd11);
            default: return tt[i];
        endcase
    endfunction

    always_comb f1 = f_model(mode_v, tt_v, {a1, b1, c1, d1});
    always_comb f3 = f_model(mode_v, tt_v, {a3, b3, c3, d3});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start1 = v; else start3 = v;
    endtask

    // One sweep from IDLE; returns the cycle done was seen (counted from the start edge)
    // and whether abcd/busy followed the expected index schedule. Ends at the done-cycle negedge.
    task automatic run_sweep(input int sel, input int glitch, output int dcyc, output bit seq_ok);
        int          cyc;
        int          st;
        bit          glitched;
        logic [3:0]  want;
        logic [3:0]  abcd;
        logic        dn, bs;
        st       = (sel == 0) ? 1 : 3;
        seq_ok   = 1'b1;
        glitched = 1'b0;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        cyc = 1;
        forever begin
            abcd = (sel == 0) ? {a1, b1, c1, d1} : {a3, b3, c3, d3};
            dn   = (sel == 0) ? done1 : done3;
            bs   = (sel == 0) ? busy1 : busy3;
            if (dn || cyc >= 300) break;
            want = 4'((cyc - 1) / (st + 1));
            if (abcd !== want || bs !== 1'b1) seq_ok = 1'b0;
            if (glitch >= 0 && !glitched && abcd == 4'(glitch)) begin
                set_start(sel, 1'b1);
                glitched = 1'b1;
            end else begin
                set_start(sel, 1'b0);
            end
            @(negedge clk);
            cyc++;
        end
        set_start(sel, 1'b0);
        if (abcd !== 4'hF || bs !== 1'b0) seq_ok = 1'b0;
        dcyc = dn ? cyc : -1;
    endtask

    typedef struct {
        string       name;
        int          mode;
        logic [15:0] tt;
        logic [15:0] exp_table;
        logic        exp_pass;
        logic        exp_fv;
        logic [3:0]  exp_fi;
    } vec_t;

    initial begin
        vec_t  vecs[$];
        vec_t  v;
        int    dcyc;
        bit    seq_ok;
        int    cyc, first, second;

        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        mode_v = 0;
        tt_v   = '0;
        repeat (3) @(negedge clk);

        chk("reset_outputs", 32'({a1, b1, c1, d1, busy1, done1, pass1, tbl1}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'({busy1, done1, busy3, done3}), 32'd0);

        // Directed vectors with hand-derived expectations
        vecs.push_back('{"golden", 0, 16'h0, 16'hF830, 1'b1, 1'b0, 4'd0});
        vecs.push_back('{"stuck0", 1, 16'h0, 16'h0000, 1'b0, 1'b1, 4'd4});
        vecs.push_back('{"flip11", 2, 16'h0, 16'hF030, 1'b0, 1'b1, 4'd11});
        // Random tables, expectations from the behavioural model
        for (int k = 0; k < 6; k++) begin
            v.name = $sformatf("rand%0d", k);
            v.mode = 3;
            v.tt   = (k == 5) ? 16'hF830 : 16'($urandom);
            v.exp_fv = 1'b0;
            v.exp_fi = 4'd0;
            for (int i = 15; i >= 0; i--) begin
                v.exp_table[i] = f_model(3, v.tt, 4'(i));
                if (v.exp_table[i] != f_model(0, 16'h0, 4'(i))) begin
                    v.exp_fv = 1'b1;
                    v.exp_fi = 4'(i);
                end
            end
            v.exp_pass = (v.exp_table == 16'hF830);
            vecs.push_back(v);
        end

        foreach (vecs[n]) begin
            mode_v = vecs[n].mode;
            tt_v   = vecs[n].tt;
            run_sweep(0, -1, dcyc, seq_ok);
            chk({vecs[n].name, "_done_cycle"}, 32'(dcyc), 32'd33);
            chk({vecs[n].name, "_abcd_seq"}, 32'(seq_ok), 32'd1);
            chk({vecs[n].name, "_table"}, 32'(tbl1), 32'(vecs[n].exp_table));
            chk({vecs[n].name, "_pass"}, 32'(pass1), 32'(vecs[n].exp_pass));
`ifdef SWEEP_FAIL_LOG_EN
            chk({vecs[n].name, "_fail_valid"}, 32'(fv1), 32'(vecs[n].exp_fv));
            if (vecs[n].exp_fv)
                chk({vecs[n].name, "_fail_idx"}, 32'(fi1), 32'(vecs[n].exp_fi));
`endif
            @(negedge clk);
            chk({vecs[n].name, "_done_pulse"}, 32'({done1, busy1}), 32'd0);
            chk({vecs[n].name, "_pass_hold"}, 32'(pass1), 32'(vecs[n].exp_pass));
        end

        // SETTLE=3: each index held 4 cycles, done at cycle 65
        mode_v = 0;
        run_sweep(1, -1, dcyc, seq_ok);
        chk("settle3_done_cycle", 32'(dcyc), 32'd65);
        chk("settle3_abcd_seq", 32'(seq_ok), 32'd1);
        chk("settle3_table", 32'(tbl3), 32'h0000F830);
        chk("settle3_pass", 32'(pass3), 32'd1);
        @(negedge clk);

        // Reset at abcd=7 mid-sweep
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while ({a1, b1, c1, d1} != 4'd7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_idx7", 32'(cyc < 100), 32'd1);
        chk("partial_table_nonzero", 32'(tbl1 != 16'h0), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midsweep_reset", 32'({a1, b1, c1, d1, busy1, done1, pass1, tbl1}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 32'({busy1, done1}), 32'd0);
        run_sweep(0, -1, dcyc, seq_ok);
        chk("after_reset_done_cycle", 32'(dcyc), 32'd33);
        chk("after_reset_pass", 32'(pass1), 32'd1);
        @(negedge clk);

        // start pulsed mid-sweep at abcd=5 is ignored
        run_sweep(0, 5, dcyc, seq_ok);
        chk("glitch_done_cycle", 32'(dcyc), 32'd33);
        chk("glitch_abcd_seq", 32'(seq_ok), 32'd1);
        chk("glitch_pass", 32'(pass1), 32'd1);
        @(negedge clk);

        // start held high: back-to-back sweeps, done every 34 cycles
        start1 = 1'b1;
        cyc    = 0;
        first  = -1;
        second = -1;
        while (second < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done1) begin
                if (first < 0) first = cyc;
                else           second = cyc;
            end
        end
        start1 = 1'b0;
        chk("b2b_first_done", 32'(first), 32'd33);
        chk("b2b_period", 32'(second - first), 32'd34);
        chk("b2b_pass", 32'(pass1), 32'd1);
        repeat (2) @(negedge clk);
        chk("b2b_stops", 32'(busy1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
